icache_ctrl: RTL and testbench
==============================

Name: icache_ctrl

Overview:
- Responder end of the fetch-unit ↔ i-cache read protocol: accepts a line-read request for a PC and returns the whole cache line plus its PC with a one-cycle done pulse.
- Direct-mapped instruction cache with flop-based tag/valid/data arrays.
- On a miss, issues a line-aligned refill to memory over a simple valid/ready request channel, collects the beats, fills the line, then responds.
- Sits between the fetch unit and the instruction memory port.

Parameters:
- XLEN, 32, address width (from mmm_pkg)
- ICACHE_LINE_W, 128, line width in bits (4 instructions)
- ICACHE_OFFSET, 4, byte-offset bits per line (log2(ICACHE_LINE_W/8))
- ICACHE_SETS, 16, number of lines
- MEM_BEAT_W, 32, memory response beat width; BEATS = ICACHE_LINE_W/MEM_BEAT_W = 4

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- flush_i  in  1  abort the current fetch response (pipeline flush)
- addr_i  in  XLEN  requested PC
- read_req_i  in  1  line read request; held by requester until read_done_o
- read_done_o  out  1  single-cycle pulse: cache_out_o valid
- cache_out_o  out  icache_out_t  {pc, line}; pc = full latched request address
- mem_req_valid_o  out  1  refill request valid
- mem_req_ready_i  in  1  memory accepts request
- mem_addr_o  out  XLEN  line-aligned refill address (offset bits zero)
- mem_resp_valid_i  in  1  refill beat valid
- mem_resp_data_i  in  MEM_BEAT_W  refill beat data, lowest beat first

Behaviour:
- Reset: state IDLE; all valid bits 0; read_done_o=0, mem_req_valid_o=0, mem_addr_o=0, cache_out_o=0; beat counter 0; kill flag 0. Data/tag arrays are not reset.
- Address split: offset [ICACHE_OFFSET-1:0], index next log2(ICACHE_SETS) bits, tag = remaining upper bits.
- FSM states: IDLE, LOOKUP, MISS_REQ, REFILL, RESPOND.
- IDLE: if read_req_i && !flush_i, latch addr_i into req_addr and go to LOOKUP. flush_i wins over a simultaneous request.
- LOOKUP (cycle t+1): hit = valid[idx] && tag[idx]==req tag.
  - Hit && !flush_i: read_done_o=1, cache_out_o={req_addr, data[idx]}, go to IDLE. Hit latency is 1 cycle after acceptance.
  - Miss && !flush_i: go to MISS_REQ.
  - flush_i: go to IDLE, no done pulse.
- MISS_REQ: mem_req_valid_o=1, mem_addr_o=line-aligned req_addr. Valid and address stay stable until mem_req_ready_i. Go to REFILL on handshake with counter=0.
- REFILL: each mem_resp_valid_i writes beat k into linebuf[k*MEM_BEAT_W +: MEM_BEAT_W] and increments k. On beat BEATS-1, write data/tag and set valid[idx]=1 in the same edge, then go to RESPOND.
- RESPOND: read_done_o=1, cache_out_o={req_addr, linebuf}, go to IDLE. If the kill flag is set, suppress read_done_o and go to IDLE.
- Flush in MISS_REQ/REFILL sets the kill flag. The memory transaction is never abandoned: request stays up until accepted, all beats are consumed, and the line is still installed. Only the response is dropped. The kill flag clears on entering IDLE.
- read_req_i outside IDLE is ignored. After a done pulse, the next request is accepted in IDLE at the following cycle at the earliest.
- Worst-case miss latency with zero-wait memory: 1 (LOOKUP) + 1 (REQ) + BEATS + 1 (RESPOND) cycles.
- mem_resp_valid_i outside REFILL is a protocol error: ignored, flagged by assertion.
- Reset mid-refill returns to IDLE with all lines invalid. The memory side is reset in the same domain.

Decomposition:
- mmm_pkg (existing) gains ICACHE_SETS, ICACHE_INDEX (log2 sets), ICACHE_TAG_W, MEM_BEAT_W, ICACHE_BEATS, and icache_ctrl_state_t (enum of the five states). icache_out_t is reused unchanged.
- One sub-module: icache_mem. It holds valid/tag/data arrays with combinational read by index, a synchronous single-port write (index, tag, line, we), and async-reset clearing of valid bits.

Test Plan:
- Cold miss: req addr 0x0000_0104, memory returns beats 0xA0,0xA1,0xA2,0xA3 with zero wait. Expect mem_addr_o=0x100, done 7 cycles after acceptance, line=0x000000A3_000000A2_000000A1_000000A0, pc=0x104.
- Hit after fill: req 0x0000_010C. Expect done in LOOKUP (1 cycle), same line, pc=0x10C, no mem_req_valid_o.
- Conflict: req 0x0000_0204 (same index, different tag). Expect miss and refill; then 0x104 misses again.
- Backpressure: mem_req_ready_i low 3 cycles, beats with gaps. Expect mem_req_valid_o and mem_addr_o stable until handshake, beats placed by count, not by cycle.
- Flush mid-refill: flush_i after beat 1. Expect no read_done_o, line installed; a later req 0x104 hits in 1 cycle.
- Flush with request in IDLE and in LOOKUP-hit cycle: expect no done pulse; reset mid-REFILL leaves all lines invalid and outputs 0.

Source files
------------

// File: rtl/mmm_pkg.sv
// Shared fetch-path definitions: address geometry, i-cache geometry,
// refill beat geometry, the fetch response record and the i-cache
// controller state type.
package mmm_pkg;

  localparam int unsigned XLEN              = 32;
  localparam int unsigned ICACHE_LINE_W     = 128;
  localparam int unsigned ICACHE_OFFSET     = 4;
  localparam int unsigned ICACHE_SETS       = 16;
  localparam int unsigned ICACHE_INDEX      = $clog2(ICACHE_SETS);
  localparam int unsigned ICACHE_TAG_W      = XLEN - ICACHE_INDEX - ICACHE_OFFSET;
  localparam int unsigned MEM_BEAT_W        = 32;
  localparam int unsigned ICACHE_BEATS      = ICACHE_LINE_W / MEM_BEAT_W;
  localparam int unsigned ICACHE_BEAT_CNT_W = $clog2(ICACHE_BEATS);

  typedef struct packed {
    logic [XLEN-1:0]          pc;
    logic [ICACHE_LINE_W-1:0] line;
  } icache_out_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MISS_REQ,
    REFILL,
    RESPOND
  } icache_ctrl_state_t;

endpackage

// File: rtl/icache_mem.sv
// Flop-based storage for the direct-mapped i-cache.
// Ports:
//   clk, rst_n        clock, async active-low reset (clears valid bits only)
//   idx               set index used for both read and write
//   rd_valid/rd_tag/rd_line  combinational read of the indexed set
//   we, wr_tag, wr_line      synchronous write of the indexed set; sets valid
module icache_mem
  import mmm_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ICACHE_INDEX-1:0]  idx,
  output logic                     rd_valid,
  output logic [ICACHE_TAG_W-1:0]  rd_tag,
  output logic [ICACHE_LINE_W-1:0] rd_line,
  input  logic                     we,
  input  logic [ICACHE_TAG_W-1:0]  wr_tag,
  input  logic [ICACHE_LINE_W-1:0] wr_line
);

  logic [ICACHE_SETS-1:0]   valid;
  logic [ICACHE_TAG_W-1:0]  tags [ICACHE_SETS];
  logic [ICACHE_LINE_W-1:0] data [ICACHE_SETS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (we) begin
      valid[idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tags[idx] <= wr_tag;
      data[idx] <= wr_line;
    end
  end

  assign rd_valid = valid[idx];
  assign rd_tag   = tags[idx];
  assign rd_line  = data[idx];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: responds to fetch-unit line
// reads, refilling missing lines from memory one beat at a time.
// Ports:
//   clk_i, rst_n_i          clock, async active-low reset
//   flush_i                 drop the response of the fetch in flight
//   addr_i, read_req_i      request PC and request strobe (held until done)
//   read_done_o             one-cycle pulse qualifying cache_out_o
//   cache_out_o             {pc, line} response
//   mem_req_valid_o/ready_i refill request handshake, mem_addr_o line-aligned
//   mem_resp_valid_i/data_i refill beats, lowest beat first
module icache_ctrl
  import mmm_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic [XLEN-1:0]       addr_i,
  input  logic                  read_req_i,
  output logic                  read_done_o,
  output icache_out_t           cache_out_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [XLEN-1:0]       mem_addr_o,
  input  logic                  mem_resp_valid_i,
  input  logic [MEM_BEAT_W-1:0] mem_resp_data_i
);

  icache_ctrl_state_t state, state_nxt;

  logic [XLEN-1:0]              req_addr;
  logic [ICACHE_BEAT_CNT_W-1:0] beat_cnt;
  logic [ICACHE_LINE_W-1:0]     linebuf;
  logic [ICACHE_LINE_W-1:0]     fill_line;
  logic                         kill;

  logic [ICACHE_INDEX-1:0]      req_idx;
  logic [ICACHE_TAG_W-1:0]      req_tag;
  logic                         rd_valid;
  logic [ICACHE_TAG_W-1:0]      rd_tag;
  logic [ICACHE_LINE_W-1:0]     rd_line;
  logic                         hit;
  logic                         beat;
  logic                         last_beat;

  assign req_idx   = req_addr[ICACHE_OFFSET +: ICACHE_INDEX];
  assign req_tag   = req_addr[XLEN-1 -: ICACHE_TAG_W];
  assign hit       = rd_valid && (rd_tag == req_tag);
  assign beat      = (state == REFILL) && mem_resp_valid_i;
  assign last_beat = beat && (beat_cnt == ICACHE_BEAT_CNT_W'(ICACHE_BEATS - 1));

  // Line buffer with the arriving beat merged in, so the final beat can be
  // installed into the array on the same edge it arrives.
  always_comb begin
    fill_line = linebuf;
    fill_line[int'(beat_cnt) * MEM_BEAT_W +: MEM_BEAT_W] = mem_resp_data_i;
  end

  icache_mem u_mem (
    .clk      (clk_i),
    .rst_n    (rst_n_i),
    .idx      (req_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .we       (last_beat),
    .wr_tag   (req_tag),
    .wr_line  (fill_line)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      req_addr <= '0;
      beat_cnt <= '0;
      linebuf  <= '0;
      kill     <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && read_req_i && !flush_i) begin
        req_addr <= addr_i;
      end
      if (state == MISS_REQ) begin
        beat_cnt <= '0;
      end else if (beat) begin
        linebuf  <= fill_line;
        beat_cnt <= beat_cnt + 1'b1;
      end
      // A flush during the memory transaction only drops the eventual
      // response; the refill itself still completes and installs the line.
      if (state_nxt == IDLE) begin
        kill <= 1'b0;
      end else if (((state == MISS_REQ) || (state == REFILL)) && flush_i) begin
        kill <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    read_done_o     = 1'b0;
    cache_out_o     = '0;
    mem_req_valid_o = 1'b0;
    mem_addr_o      = '0;
    unique case (state)
      IDLE: begin
        if (read_req_i && !flush_i) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (flush_i) begin
          state_nxt = IDLE;
        end else if (hit) begin
          read_done_o      = 1'b1;
          cache_out_o.pc   = req_addr;
          cache_out_o.line = rd_line;
          state_nxt        = IDLE;
        end else begin
          state_nxt = MISS_REQ;
        end
      end
      MISS_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_addr_o      = {req_addr[XLEN-1:ICACHE_OFFSET], {ICACHE_OFFSET{1'b0}}};
        if (mem_req_ready_i) state_nxt = REFILL;
      end
      REFILL: begin
        if (last_beat) state_nxt = RESPOND;
      end
      RESPOND: begin
        if (!kill) begin
          read_done_o      = 1'b1;
          cache_out_o.pc   = req_addr;
          cache_out_o.line = linebuf;
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  a_resp_in_refill: assert property (
    @(posedge clk_i) disable iff (!rst_n_i) mem_resp_valid_i |-> (state == REFILL)
  );

endmodule

// File: tb/tb_icache_ctrl.sv
module tb_icache_ctrl;
  import mmm_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  flush = 1'b0;
  logic [XLEN-1:0]       addr = '0;
  logic                  read_req = 1'b0;
  logic                  read_done;
  icache_out_t           cache_out;
  logic                  mem_req_valid;
  logic                  mem_req_ready = 1'b0;
  logic [XLEN-1:0]       mem_addr;
  logic                  mem_resp_valid = 1'b0;
  logic [MEM_BEAT_W-1:0] mem_resp_data = '0;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  icache_ctrl dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .flush_i          (flush),
    .addr_i           (addr),
    .read_req_i       (read_req),
    .read_done_o      (read_done),
    .cache_out_o      (cache_out),
    .mem_req_valid_o  (mem_req_valid),
    .mem_req_ready_i  (mem_req_ready),
    .mem_addr_o       (mem_addr),
    .mem_resp_valid_i (mem_resp_valid),
    .mem_resp_data_i  (mem_resp_data)
  );

  // ---------------- memory contents and cache reference model -------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if ((a >> 4) == 32'h10) return 32'hA0 + ((a >> 2) & 32'h3);
    return (a * 32'h9E3779B1) ^ 32'hC0DE0000;
  endfunction

  function automatic logic [127:0] mem_line(input logic [31:0] a);
    logic [127:0] l;
    logic [31:0]  base;
    base = (a / 16) * 16;
    for (int k = 0; k < 4; k++) l[k*32 +: 32] = mem_word(base + 32'(4 * k));
    return l;
  endfunction

  bit          mvalid [16];
  int unsigned mline  [16];

  function automatic bit model_hit(input logic [31:0] a);
    int unsigned n = a / 16;
    return mvalid[n % 16] && (mline[n % 16] == n);
  endfunction

  function automatic void model_fill(input logic [31:0] a);
    int unsigned n = a / 16;
    mvalid[n % 16] = 1'b1;
    mline[n % 16]  = n;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
  endfunction

  // ---------------- memory responder --------------------------------------
  int          ready_delay = 0;
  int          gap_mode = 0;      // 0: back-to-back, 1: fixed gaps, 2: random gaps
  int          mem_reqs = 0;
  int          last_gaps = 0;
  int          stab_errs = 0;
  logic [31:0] last_req_addr = '0;

  initial begin : memory
    logic [31:0] a0;
    int          gap;
    bit          abort;
    int          pat [4];
    pat = '{1, 0, 2, 1};
    forever begin
      @(negedge clk);
      if (rst_n && mem_req_valid) begin
        abort = 1'b0;
        a0    = mem_addr;
        for (int d = 0; d < ready_delay; d++) begin
          @(negedge clk);
          if (!rst_n) begin abort = 1'b1; break; end
          if (mem_req_valid !== 1'b1 || mem_addr !== a0) stab_errs++;
        end
        if (!abort) begin
          mem_req_ready = 1'b1;
          @(negedge clk);
          mem_req_ready = 1'b0;
          mem_reqs++;
          last_req_addr = a0;
          last_gaps     = 0;
          if (!rst_n) abort = 1'b1;
        end
        for (int k = 0; k < 4 && !abort; k++) begin
          gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? pat[k] : int'($urandom_range(0, 2));
          last_gaps += gap;
          repeat (gap) begin
            @(negedge clk);
            if (!rst_n) abort = 1'b1;
          end
          if (abort) break;
          mem_resp_valid = 1'b1;
          mem_resp_data  = mem_word(a0 + 32'(4 * k));
          @(negedge clk);
          mem_resp_valid = 1'b0;
          if (!rst_n) abort = 1'b1;
        end
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b0;
      end
    end
  end

  // ---------------- request driver ----------------------------------------
  // flush_at < 0: plain fetch, stops at the first done pulse.
  // flush_at >= 0: flush in cycle flush_at after issue (0 = issue cycle),
  //                request dropped from then on, runs all max_cyc cycles.
  task automatic run_fetch(input logic [31:0] a, input int flush_at, input int max_cyc,
                           output int ndone, output int lat, output icache_out_t out);
    ndone = 0;
    lat   = -1;
    out   = '0;
    @(negedge clk);
    addr     = a;
    read_req = 1'b1;
    flush    = (flush_at == 0);
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge clk);
      if (flush_at >= 0 && k >= flush_at) read_req = 1'b0;
      flush = (k == flush_at);
      #1;
      if (read_done === 1'b1) begin
        ndone++;
        if (lat < 0) begin lat = k; out = cache_out; end
        read_req = 1'b0;
        if (flush_at < 0) break;
      end
    end
    flush    = 1'b0;
    read_req = 1'b0;
  endtask

  // ---------------- scenarios ---------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (read_done !== 1'b0) $display("FAIL reset_done: got %b want 0", read_done); else passed++;
    checks++; if (mem_req_valid !== 1'b0) $display("FAIL reset_mem_valid: got %b want 0", mem_req_valid); else passed++;
    checks++; if (mem_addr !== '0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr); else passed++;
    checks++; if (cache_out !== '0) $display("FAIL reset_cache_out: got %h want 0", cache_out); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_cold_miss();
    int nd, lat, r0;
    icache_out_t o;
    ready_delay = 0; gap_mode = 0;
    r0 = mem_reqs;
    run_fetch(32'h104, -1, 100, nd, lat, o);
    checks++; if (lat != 7) $display("FAIL cold_latency: got %0d want 7", lat); else passed++;
    checks++; if (o.pc !== 32'h104) $display("FAIL cold_pc: got %h want 00000104", o.pc); else passed++;
    checks++; if (o.line !== 128'h000000A3_000000A2_000000A1_000000A0)
      $display("FAIL cold_line: got %h want 000000a3000000a2000000a1000000a0", o.line); else passed++;
    checks++; if (last_req_addr !== 32'h100) $display("FAIL cold_mem_addr: got %h want 00000100", last_req_addr); else passed++;
    checks++; if (mem_reqs - r0 != 1) $display("FAIL cold_mem_reqs: got %0d want 1", mem_reqs - r0); else passed++;
    model_fill(32'h104);
  endtask

  task automatic test_hit();
    int nd, lat, r0;
    icache_out_t o;
    r0 = mem_reqs;
    run_fetch(32'h10C, -1, 100, nd, lat, o);
    checks++; if (lat != 1) $display("FAIL hit_latency: got %0d want 1", lat); else passed++;
    checks++; if (o.pc !== 32'h10C) $display("FAIL hit_pc: got %h want 0000010c", o.pc); else passed++;
    checks++; if (o.line !== 128'h000000A3_000000A2_000000A1_000000A0)
      $display("FAIL hit_line: got %h want 000000a3000000a2000000a1000000a0", o.line); else passed++;
    checks++; if (mem_reqs != r0) $display("FAIL hit_mem_reqs: got %0d want 0", mem_reqs - r0); else passed++;
  endtask

  task automatic test_conflict();
    int nd, lat, r0;
    icache_out_t o;
    logic [31:0] seq [2];
    seq = '{32'h204, 32'h104};
    foreach (seq[i]) begin
      r0 = mem_reqs;
      run_fetch(seq[i], -1, 100, nd, lat, o);
      checks++; if (lat != 7) $display("FAIL conflict_latency[%0d]: got %0d want 7", i, lat); else passed++;
      checks++; if (o.line !== mem_line(seq[i]))
        $display("FAIL conflict_line[%0d]: got %h want %h", i, o.line, mem_line(seq[i])); else passed++;
      checks++; if (last_req_addr !== (seq[i] & ~32'hF) || mem_reqs - r0 != 1)
        $display("FAIL conflict_refill[%0d]: got addr %h reqs %0d want addr %h reqs 1",
                 i, last_req_addr, mem_reqs - r0, seq[i] & ~32'hF); else passed++;
      model_fill(seq[i]);
    end
  endtask

  task automatic test_backpressure();
    int nd, lat;
    icache_out_t o;
    ready_delay = 3; gap_mode = 1; stab_errs = 0;
    run_fetch(32'h3A8, -1, 100, nd, lat, o);
    checks++; if (lat != 14) $display("FAIL bp_latency: got %0d want 14", lat); else passed++;
    checks++; if (stab_errs != 0) $display("FAIL bp_req_stable: got %0d unstable cycles want 0", stab_errs); else passed++;
    checks++; if (o.line !== mem_line(32'h3A8)) $display("FAIL bp_line: got %h want %h", o.line, mem_line(32'h3A8)); else passed++;
    checks++; if (o.pc !== 32'h3A8 || last_req_addr !== 32'h3A0)
      $display("FAIL bp_addr: got pc %h mem %h want pc 000003a8 mem 000003a0", o.pc, last_req_addr); else passed++;
    model_fill(32'h3A8);
    ready_delay = 0; gap_mode = 0;
  endtask

  task automatic test_flush_refill();
    int nd, lat, r0;
    icache_out_t o;
    run_fetch(32'h204, -1, 100, nd, lat, o);
    model_fill(32'h204);
    r0 = mem_reqs;
    run_fetch(32'h104, 5, 20, nd, lat, o);
    checks++; if (nd != 0) $display("FAIL flush_refill_done: got %0d pulses want 0", nd); else passed++;
    checks++; if (mem_reqs - r0 != 1) $display("FAIL flush_refill_reqs: got %0d want 1", mem_reqs - r0); else passed++;
    model_fill(32'h104);
    r0 = mem_reqs;
    run_fetch(32'h104, -1, 100, nd, lat, o);
    checks++; if (lat != 1 || mem_reqs != r0)
      $display("FAIL flush_refill_installed: got latency %0d reqs %0d want latency 1 reqs 0", lat, mem_reqs - r0); else passed++;
    checks++; if (o.line !== mem_line(32'h104)) $display("FAIL flush_refill_line: got %h want %h", o.line, mem_line(32'h104)); else passed++;
  endtask

  task automatic test_flush_idle_lookup();
    int nd, lat, r0;
    icache_out_t o;
    r0 = mem_reqs;
    run_fetch(32'h108, 0, 10, nd, lat, o);
    checks++; if (nd != 0 || mem_reqs != r0)
      $display("FAIL flush_idle: got %0d pulses %0d reqs want 0 0", nd, mem_reqs - r0); else passed++;
    run_fetch(32'h108, 1, 10, nd, lat, o);
    checks++; if (nd != 0) $display("FAIL flush_lookup_hit: got %0d pulses want 0", nd); else passed++;
    run_fetch(32'h108, -1, 100, nd, lat, o);
    checks++; if (lat != 1 || o.pc !== 32'h108)
      $display("FAIL after_flush_hit: got latency %0d pc %h want 1 00000108", lat, o.pc); else passed++;
  endtask

  task automatic test_reset_mid_refill();
    int nd, lat, r0;
    icache_out_t o;
    @(negedge clk);
    addr = 32'h5C0; read_req = 1'b1;
    @(negedge clk);
    read_req = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (read_done !== 1'b0 || mem_req_valid !== 1'b0)
      $display("FAIL midreset_ctrl: got done %b valid %b want 0 0", read_done, mem_req_valid); else passed++;
    checks++; if (mem_addr !== '0 || cache_out !== '0)
      $display("FAIL midreset_data: got addr %h out %h want 0", mem_addr, cache_out); else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    r0 = mem_reqs;
    run_fetch(32'h104, -1, 100, nd, lat, o);
    checks++; if (lat != 7 || mem_reqs - r0 != 1)
      $display("FAIL midreset_invalid: got latency %0d reqs %0d want 7 1", lat, mem_reqs - r0); else passed++;
    model_fill(32'h104);
  endtask

  task automatic test_random();
    int nd, lat, r0, exp_lat;
    bit exp_hit;
    icache_out_t o;
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      a = 32'h1000 * $urandom_range(0, 2) + 32'h10 * $urandom_range(0, 15) + 32'h4 * $urandom_range(0, 3);
      ready_delay = $urandom_range(0, 2);
      gap_mode    = $urandom_range(0, 2);
      exp_hit     = model_hit(a);
      r0 = mem_reqs;
      run_fetch(a, -1, 100, nd, lat, o);
      exp_lat = exp_hit ? 1 : 7 + ready_delay + last_gaps;
      checks++; if (lat != exp_lat) $display("FAIL rnd_latency[%0d]: addr %h got %0d want %0d", i, a, lat, exp_lat); else passed++;
      checks++; if (mem_reqs - r0 != (exp_hit ? 0 : 1))
        $display("FAIL rnd_refill[%0d]: addr %h got %0d reqs want %0d", i, a, mem_reqs - r0, exp_hit ? 0 : 1); else passed++;
      checks++; if (o.pc !== a) $display("FAIL rnd_pc[%0d]: got %h want %h", i, o.pc, a); else passed++;
      checks++; if (o.line !== mem_line(a)) $display("FAIL rnd_line[%0d]: got %h want %h", i, o.line, mem_line(a)); else passed++;
      model_fill(a);
    end
    ready_delay = 0; gap_mode = 0;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_backpressure();
    test_flush_refill();
    test_flush_idle_lookup();
    test_reset_mid_refill();
    test_random();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
